// File: rtl/regfile_alu_sequencer.sv
// regfile_alu_sequencer
// Buffers encoded datapath instructions in a small FIFO and decodes them,
// one per cycle at most, into the registered regfile/ALU control bundle
// (rs, rd, opcode, one-hot re, ri, fe, imm).
// Handles a datapath stall, a two-word immediate form, HALT/resume and a
// synchronous flush.
// Optional feature macro: ISSUE_COUNT_EN adds the 16-bit issue_count output.
module regfile_alu_sequencer #(
  parameter int DEPTH  = 4,
  parameter int WORD_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_word,
  output logic              in_ready,
  input  logic              stall,
  input  logic              flush,
  input  logic              resume,
  output logic [3:0]        rs,
  output logic [3:0]        rd,
  output logic [4:0]        opcode,
  output logic [15:0]       re,
  output logic              ri,
  output logic              fe,
  output logic [15:0]       imm,
  output logic              issue_valid,
`ifdef ISSUE_COUNT_EN
  output logic [15:0]       issue_count,
`endif
  output logic              halted
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [4:0] OP_HALT = 5'b11111;

  // Field layout of the first instruction word
  typedef struct packed {
    logic [4:0] opcode;
    logic       ri;
    logic       fe;
    logic       rsvd;
    logic [3:0] wr;
    logic [3:0] rd;
    logic [3:0] rs;
  } instr_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_IMM,
    S_HALTED
  } state_t;

  // ---------------------------------------------------------------------
  // FIFO storage and bookkeeping
  // ---------------------------------------------------------------------
  logic [WORD_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic              empty, full, push, pop;
  instr_t            head;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign in_ready = !full;
  // A push while full is refused even if a pop happens on the same edge.
  assign push     = in_valid && !full;
  assign head     = instr_t'(mem[rd_ptr]);

  // ---------------------------------------------------------------------
  // Sequencer FSM and decode signals
  // ---------------------------------------------------------------------
  state_t state, next_state;
  instr_t word0_q;     // first word held while waiting for the extension
  logic   latch_en;
  logic   do_issue;
  instr_t issue_word;
  logic [15:0] issue_imm;
  logic [15:0] re_dec;

  // Pointer/count update; flush empties the FIFO and drops any push
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage write; entries are only read after being written
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; count/pointers already mark
    // every entry invalid, so clearing it would only cost reset fan-out.
    if (push && !flush) mem[wr_ptr] <= in_word;
  end

  // Next-state, pop and issue decisions
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned, which would infer a latch.
    next_state = state;
    pop        = 1'b0;
    do_issue   = 1'b0;
    latch_en   = 1'b0;
    issue_word = head;
    issue_imm  = 16'h0000;
    case (state)
      S_IDLE: begin
        if (!empty && !stall) begin
          pop = 1'b1;
          if (head.opcode == OP_HALT) begin
            next_state = S_HALTED;
          end else if (head.ri) begin
            latch_en   = 1'b1;
            next_state = S_WAIT_IMM;
          end else begin
            do_issue = 1'b1;
          end
        end
      end
      S_WAIT_IMM: begin
        if (!empty && !stall) begin
          pop        = 1'b1;
          do_issue   = 1'b1;
          issue_word = word0_q;
          issue_imm  = mem[rd_ptr][15:0];
          next_state = S_IDLE;
        end
      end
      S_HALTED: begin
        if (resume) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // One-hot write enable; writes to R0 are suppressed
  always_comb begin
    re_dec = 16'h0000;
    if (issue_word.wr != 4'd0) re_dec = 16'h0001 << issue_word.wr;
  end

  // State register and word0 latch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      word0_q <= '0;
    end else if (flush) begin
      state   <= S_IDLE;
      word0_q <= '0;
    end else begin
      state <= next_state;
      if (latch_en) word0_q <= head;
    end
  end

  // Registered control bundle: valid for exactly the cycle after the decision
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rs          <= '0;
      rd          <= '0;
      opcode      <= '0;
      re          <= '0;
      ri          <= 1'b0;
      fe          <= 1'b0;
      imm         <= '0;
      issue_valid <= 1'b0;
    end else if (flush || !do_issue) begin
      rs          <= '0;
      rd          <= '0;
      opcode      <= '0;
      re          <= '0;
      ri          <= 1'b0;
      fe          <= 1'b0;
      imm         <= '0;
      issue_valid <= 1'b0;
    end else begin
      rs          <= issue_word.rs;
      rd          <= issue_word.rd;
      opcode      <= issue_word.opcode;
      re          <= re_dec;
      ri          <= issue_word.ri;
      fe          <= issue_word.fe;
      imm         <= issue_imm;
      issue_valid <= 1'b1;
    end
  end

  assign halted = (state == S_HALTED);

`ifdef ISSUE_COUNT_EN
  // Count of issued instructions (R0 writes included, HALT excluded)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          issue_count <= '0;
    else if (flush)    issue_count <= '0;
    else if (do_issue) issue_count <= issue_count + 16'd1;
  end
`endif

  // Bit 12 of word0 and ext[19:16] carry no meaning
  logic unused_bits;
  assign unused_bits = issue_word.rsvd ^ (^mem[rd_ptr][WORD_W-1:16]);

endmodule

// File: tb/tb_regfile_alu_sequencer.sv
// Directed testbench for regfile_alu_sequencer (DEPTH=4).
module tb_regfile_alu_sequencer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [19:0] in_word;
  logic        in_ready;
  logic        stall, flush, resume;
  logic [3:0]  rs, rd;
  logic [4:0]  opcode;
  logic [15:0] re;
  logic        ri, fe;
  logic [15:0] imm;
  logic        issue_valid;
  logic        halted;
`ifdef ISSUE_COUNT_EN
  logic [15:0] issue_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  regfile_alu_sequencer #(.DEPTH(4), .WORD_W(20)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_word     (in_word),
    .in_ready    (in_ready),
    .stall       (stall),
    .flush       (flush),
    .resume      (resume),
    .rs          (rs),
    .rd          (rd),
    .opcode      (opcode),
    .re          (re),
    .ri          (ri),
    .fe          (fe),
    .imm         (imm),
    .issue_valid (issue_valid),
`ifdef ISSUE_COUNT_EN
    .issue_count (issue_count),
`endif
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word for exactly one edge
  task automatic push_word(input logic [19:0] w);
    in_valid = 1'b1;
    in_word  = w;
    tick();
    in_valid = 1'b0;
  endtask

  // All bundle outputs idle (halted is checked separately)
  task automatic check_idle(input string tag);
    check({tag, ".valid"}, 32'(issue_valid), 32'd0);
    check({tag, ".re"},    32'(re),          32'd0);
    check({tag, ".fe"},    32'(fe),          32'd0);
    check({tag, ".bund"},  {8'd0, rs, rd, opcode, ri, imm[8:0]}, 32'd0);
    check({tag, ".imm"},   32'(imm),         32'd0);
  endtask

  task automatic check_issue(input string tag, input logic [4:0] e_op, input logic [3:0] e_rd,
                             input logic [3:0] e_rs, input logic [15:0] e_re, input logic e_ri,
                             input logic e_fe, input logic [15:0] e_imm);
    check({tag, ".valid"},  32'(issue_valid), 32'd1);
    check({tag, ".opcode"}, 32'(opcode),      32'(e_op));
    check({tag, ".rd"},     32'(rd),          32'(e_rd));
    check({tag, ".rs"},     32'(rs),          32'(e_rs));
    check({tag, ".re"},     32'(re),          32'(e_re));
    check({tag, ".ri"},     32'(ri),          32'(e_ri));
    check({tag, ".fe"},     32'(fe),          32'(e_fe));
    check({tag, ".imm"},    32'(imm),         32'(e_imm));
  endtask

  initial begin
    logic [19:0] w;
    rst = 1'b0; in_valid = 1'b0; in_word = '0;
    stall = 1'b0; flush = 1'b0; resume = 1'b0;

    // ---- reset state ----
    #2;
    check_idle("rst");
    check("rst.halted", 32'(halted),   32'd0);
    check("rst.ready",  32'(in_ready), 32'd1);
    tick(); tick();
    rst = 1'b1;
    tick();

    // ---- single-word issue, latency N+2, stall does not extend ----
    // opcode=00101 ri=0 fe=1 wr=2 rd=1 rs=0
    push_word(20'h2A210);
    check("lat.n1", 32'(issue_valid), 32'd0);
    tick();
    check_issue("single", 5'b00101, 4'd1, 4'd0, 16'h0004, 1'b0, 1'b1, 16'h0000);
    stall = 1'b1;
    tick();
    check_idle("single.after");
    stall = 1'b0;
    tick();

    // ---- two-word immediate form, back-to-back ----
    // opcode=00101 ri=1 fe=0 wr=1 rd=0 rs=0, then ext 0x00001
    in_valid = 1'b1; in_word = 20'h2C100;
    tick();
    in_word = 20'h00001;
    tick();
    in_valid = 1'b0;
    check("imm.n2", 32'(issue_valid), 32'd0);
    tick();
    check_issue("imm", 5'b00101, 4'd0, 4'd0, 16'h0002, 1'b1, 1'b0, 16'h0001);
    tick();
    check_idle("imm.after");
    tick();
    check("imm.noext", 32'(issue_valid), 32'd0);

    // ---- fill with stall high, 5th push refused, then drain ----
    stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_word  = {5'b00001, 3'b000, 4'(k + 1), 4'(k), 4'd0};
      tick();
      if (k == 3) check("full.ready4", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    check("full.ready5", 32'(in_ready),    32'd0);
    check("full.noiss",  32'(issue_valid), 32'd0);
    stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_issue($sformatf("drain%0d", k), 5'b00001, 4'(k), 4'd0,
                  16'h0001 << (k + 1), 1'b0, 1'b0, 16'h0000);
    end
    tick();
    check_idle("drain.after");
    check("drain.ready", 32'(in_ready), 32'd1);
    tick();
    check("drain.no5th", 32'(issue_valid), 32'd0);

    // ---- HALT then ADD, resume ----
    in_valid = 1'b1; in_word = 20'hF8000;           // HALT
    tick();
    in_word = 20'h10321;                            // opcode=00010 wr=3 rd=2 rs=1
    tick();
    in_valid = 1'b0;
    check("halt.set",   32'(halted),      32'd1);
    check("halt.noiss", 32'(issue_valid), 32'd0);
    tick(); tick();
    check("halt.hold",  32'(halted),      32'd1);
    check("halt.wait",  32'(issue_valid), 32'd0);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    check("resume.clr",   32'(halted),      32'd0);
    check("resume.noiss", 32'(issue_valid), 32'd0);
    tick();
    check_issue("add", 5'b00010, 4'd2, 4'd1, 16'h0008, 1'b0, 1'b0, 16'h0000);

    // ---- write to R0: issued, no write enable ----
    tick();
    push_word(20'h1A056);                           // opcode=00011 fe=1 wr=0 rd=5 rs=6
    tick();
    check_issue("r0", 5'b00011, 4'd5, 4'd6, 16'h0000, 1'b0, 1'b1, 16'h0000);
`ifdef ISSUE_COUNT_EN
    check("cnt.r0", 32'(issue_count), 32'd8);
`endif
    tick();

    // ---- flush with a push in the same cycle ----
    stall = 1'b1;
    push_word(20'h08111);
    push_word(20'h08222);
    push_word(20'h08333);
    in_valid = 1'b1; in_word = 20'h08444; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0; stall = 1'b0;
    check("flush.ready", 32'(in_ready), 32'd1);
    check_idle("flush");
`ifdef ISSUE_COUNT_EN
    check("cnt.flush", 32'(issue_count), 32'd0);
`endif
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("flush.noiss%0d", k), 32'(issue_valid), 32'd0);
    end
    // First word after flush must be the next one issued
    push_word(20'h08AB5);                           // opcode=00001 wr=10 rd=11 rs=5
    tick();
    check_issue("postflush", 5'b00001, 4'd11, 4'd5, 16'h0400, 1'b0, 1'b0, 16'h0000);
`ifdef ISSUE_COUNT_EN
    check("cnt.post", 32'(issue_count), 32'd1);
`endif
    tick();

    // ---- reset while in WAIT_IMM ----
    push_word(20'h2C100);                           // ri form, no extension yet
    tick();                                         // now waiting for extension
    rst = 1'b0;
    #1;
    check_idle("rstmid");
    check("rstmid.halted", 32'(halted),   32'd0);
    check("rstmid.ready",  32'(in_ready), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    check("rstmid.noiss", 32'(issue_valid), 32'd0);
    // Word treated as a fresh single-word instruction, not an extension
    w = 20'h00007;                                  // opcode=0 ri=0 rs=7
    push_word(w);
    tick();
    check_issue("rstmid.fresh", 5'b00000, 4'd0, 4'd7, 16'h0000, 1'b0, 1'b0, 16'h0000);
    tick();
    check_idle("end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_alu_sequencer.md
Name: regfile_alu_sequencer

Overview:
- Programmable replacement for the hard-wired datapath sequence. Accepts encoded datapath instructions over a valid/ready stream and buffers them in a small FIFO.
- Decodes each instruction into the register-file/ALU control bundle: rs, rd, opcode, one-hot re, ri, fe and imm.
- Issues at most one instruction per cycle. Supports a datapath stall, a two-word immediate form, a HALT instruction and a synchronous flush.
- Sits between the instruction source (test harness or future fetch unit) and the regfile/ALU datapath.

Parameters:
- DEPTH, 4, FIFO depth in words; power of two, at least 2.
- WORD_W, 20, input word width; fixed encoding below, other values unsupported.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-low
- in_valid  input  1  in_word valid
- in_word  input  20  instruction or extension word
- in_ready  output  1  FIFO can accept a word
- stall  input  1  datapath busy; no issue this cycle
- flush  input  1  synchronous clear of FIFO and FSM
- resume  input  1  leave HALTED
- rs  output  4  source read select
- rd  output  4  destination read select
- opcode  output  5  ALU opcode
- re  output  16  one-hot register write enable
- ri  output  1  immediate operand select
- fe  output  1  flag register write enable
- imm  output  16  immediate value
- issue_valid  output  1  control bundle valid this cycle
- halted  output  1  sequencer in HALTED state

Behaviour:
- Encoding of word0:
  - [19:15] opcode; [14] ri; [13] fe; [11:8] wr (write target); [7:4] rd; [3:0] rs; bit 12 ignored.
  - When ri=1, the next FIFO word is the extension word; imm = ext[15:0], ext[19:16] ignored.
- Opcode 5'b11111 is HALT: it produces no issue.
- Reset and idle values (registered outputs): rs=0, rd=0, opcode=0, re=0, ri=0, fe=0, imm=0, issue_valid=0, halted=0. FIFO empty, FSM in IDLE.
- Every non-issue cycle drives the idle values except halted. re and fe are never asserted without issue_valid.
- FIFO push: in_valid && in_ready at a posedge. in_ready = (count != DEPTH).
  - A push while full is refused, even if a pop occurs in the same cycle.
  - Push and pop in the same cycle when not full: count unchanged. Pointers wrap modulo DEPTH.
- FSM states: IDLE, WAIT_IMM, HALTED.
- IDLE, FIFO non-empty, stall=0:
  - Pop the head word.
  - If opcode==HALT, go to HALTED.
  - Else if ri=0, issue.
  - Else latch word0 and go to WAIT_IMM (no issue).
- IDLE with stall=1 or FIFO empty: no pop, no issue.
- WAIT_IMM, FIFO non-empty, stall=0: pop the extension word, issue the latched word0 with imm, return to IDLE. Otherwise wait; the latched word0 is held.
- HALTED: halted=1, no pops. A resume sampled high sets halted=0 at the next edge and returns to IDLE. FIFO contents are preserved and push continues.
- Issue: the control bundle is registered at the decision edge and visible for exactly one cycle with issue_valid=1.
  - re = (wr==0) ? 0 : (1<<wr). Writes to R0 are suppressed but the instruction still counts as issued.
  - fe as encoded. imm = 0 when ri=0.
- Latency: a word pushed at edge N into an empty FIFO, with stall low, gives issue_valid=1 during cycle N+2. The ri form gives N+3 if both words are pushed back-to-back.
- Throughput: one single-word instruction per cycle while the FIFO stays non-empty and stall stays low.
- flush (synchronous, highest priority after reset):
  - Empties the FIFO, returns the FSM to IDLE, clears halted and the WAIT_IMM latch.
  - Outputs are idle next cycle. Any push in the flush cycle is discarded.
- stall affects pops only. The bundle registered at the previous edge still appears; stall never extends it.
- Reset mid-operation: immediately forces all idle values, empties the FIFO and enters IDLE.

Optional Feature:
- Macro ISSUE_COUNT_EN.
- Defined: adds output issue_count[15:0]. It increments by 1 on each issue (including wr==0 issues) and wraps 16'hFFFF to 0. It is cleared by rst and by flush; HALT does not count.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Push word0 {opcode=00101, ri=0, fe=1, wr=2, rd=1, rs=0} at edge N, stall low -> cycle N+2: issue_valid=1, re=16'h0004, rd=1, rs=0, opcode=00101, fe=1, imm=0; cycle N+3 all idle.
- Push ri word {00101, ri=1, fe=0, wr=1, rd=0, rs=0} then ext 16'h0001 -> one issue with re=16'h0002, ri=1, imm=16'h0001, fe=0; no issue for the extension word.
- Push 5 words with DEPTH=4 and stall high -> in_ready=0 after the 4th push, 5th refused; release stall -> 4 issues on consecutive cycles in push order.
- Push HALT then an ADD -> halted=1, no issue; pulse resume -> halted=0, ADD issues 2 cycles after the resume edge.
- Instruction with wr=0 -> issue_valid=1, re=0; issue_count increments by 1 (ISSUE_COUNT_EN).
- Fill 3 words, assert flush with in_valid high -> FIFO empty, in_ready=1, no issue afterwards; assert rst while in WAIT_IMM -> all outputs idle, no issue after release.
